// File: rtl/alu_shift_ctrl_if.sv
// Request/response handshake bundle between ALU op decode (master) and the shift sequencer (slave).
interface alu_shift_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_operand;
  logic [AMT_W-1:0] req_amt;
  logic             req_dir;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;

  modport master (
    output req_valid, req_operand, req_amt, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_operand, req_amt, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_shift_ctrl.sv
// Sequencer for the ALU's 1-bit-per-cycle load/shift register: one request at a time.
// Optional macro ALU_SHIFT_CTRL_SAT_BYPASS_EN: amounts >= WIDTH skip the shifter and return 0.
module alu_shift_ctrl #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_shift_ctrl_if.slave  bus,
  output logic [WIDTH-1:0] sh_operand,
  output logic             sh_l_enable,
  output logic             sh_shift_l_r,
  input  logic [WIDTH-1:0] sh_result,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

  state_t           state;
  logic [AMT_W-1:0] cnt;

  // sh_l_enable is registered one cycle ahead so it is high exactly in SHIFT cycles with cnt!=0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      sh_operand     <= '0;
      sh_l_enable    <= 1'b0;
      sh_shift_l_r   <= 1'b0;
      busy           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            busy          <= 1'b1;
            sh_operand    <= bus.req_operand;
            sh_shift_l_r  <= bus.req_dir;
`ifdef ALU_SHIFT_CTRL_SAT_BYPASS_EN
            if (bus.req_amt >= AMT_MAX) begin
              cnt            <= '0;
              bus.rsp_result <= '0;
              bus.rsp_valid  <= 1'b1;
              state          <= DONE;
            end else begin
              cnt   <= bus.req_amt;
              state <= LOAD;
            end
`else
            cnt   <= (bus.req_amt > AMT_MAX) ? AMT_MAX : bus.req_amt;
            state <= LOAD;
`endif
          end
        end
        LOAD: begin
          sh_l_enable <= (cnt != '0);
          state       <= SHIFT;
        end
        SHIFT: begin
          if (cnt != '0) begin
            cnt         <= cnt - AMT_ONE;
            sh_l_enable <= (cnt != AMT_ONE);
          end else begin
            sh_l_enable    <= 1'b0;
            bus.rsp_result <= sh_result;
            bus.rsp_valid  <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_ctrl.sv
// Bench for alu_shift_ctrl: directed vectors, a cycle-timed behavioural model and a shifter stand-in.
module tb_alu_shift_ctrl;

  localparam int WIDTH = 32;
  localparam int AMT_W = 6;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] sh_operand;
  logic             sh_l_enable;
  logic             sh_shift_l_r;
  logic [WIDTH-1:0] sh_result;
  logic             busy;
  logic [WIDTH-1:0] sh_reg;

  int checks;
  int failures;
  int cyc;

  alu_shift_ctrl_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus_if ();

  alu_shift_ctrl #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if),
    .sh_operand   (sh_operand),
    .sh_l_enable  (sh_l_enable),
    .sh_shift_l_r (sh_shift_l_r),
    .sh_result    (sh_result),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Stand-in for the external shifter: load when enable is low, else shift one bit
  always @(posedge clk) begin
    if (!sh_l_enable) sh_reg <= sh_operand;
    else if (sh_shift_l_r) sh_reg <= sh_reg >> 1;
    else sh_reg <= sh_reg << 1;
  end
  assign sh_result = sh_reg;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h cycle=%0d", name, actual, expected, cyc);
    end
  endtask

  // Behavioural model: outputs are a function of cycles elapsed since accept
  bit          m_active;
  bit          m_byp;
  int          m_acc;
  int          m_lat;
  int          m_n;
  int          m_k;
  logic [31:0] m_op;
  logic        m_dir;
  logic [31:0] m_exp;

  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst_rsp_valid", bus_if.rsp_valid, 0);
      checkOutput("rst_rsp_result", bus_if.rsp_result, 0);
      checkOutput("rst_req_ready", bus_if.req_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_sh_l_enable", sh_l_enable, 0);
      checkOutput("rst_sh_operand", sh_operand, 0);
      checkOutput("rst_sh_dir", sh_shift_l_r, 0);
      m_active = 1'b0;
    end else if (!m_active) begin
      checkOutput("idle_req_ready", bus_if.req_ready, 1);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_rsp_valid", bus_if.rsp_valid, 0);
      checkOutput("idle_sh_l_enable", sh_l_enable, 0);
      if (bus_if.req_valid) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_op     = bus_if.req_operand;
        m_dir    = bus_if.req_dir;
        m_n      = (int'(bus_if.req_amt) > WIDTH) ? WIDTH : int'(bus_if.req_amt);
        if (int'(bus_if.req_amt) >= WIDTH) m_exp = 32'h0;
        else if (m_dir) m_exp = m_op >> bus_if.req_amt;
        else m_exp = m_op << bus_if.req_amt;
`ifdef ALU_SHIFT_CTRL_SAT_BYPASS_EN
        m_byp = (int'(bus_if.req_amt) >= WIDTH);
`else
        m_byp = 1'b0;
`endif
        m_lat = m_byp ? 1 : m_n + 3;
      end
    end else begin
      m_k = cyc - m_acc;
      checkOutput("act_busy", busy, 1);
      checkOutput("act_req_ready", bus_if.req_ready, 0);
      if (!m_byp) begin
        checkOutput("act_sh_operand", sh_operand, m_op);
        checkOutput("act_sh_dir", sh_shift_l_r, m_dir);
      end
      if (m_k < m_lat) begin
        checkOutput("wait_rsp_valid", bus_if.rsp_valid, 0);
        checkOutput("wait_sh_l_enable", sh_l_enable,
                    (!m_byp && m_k >= 2 && m_k <= m_n + 1) ? 1 : 0);
      end else begin
        checkOutput("done_rsp_valid", bus_if.rsp_valid, 1);
        checkOutput("done_rsp_result", bus_if.rsp_result, m_exp);
        checkOutput("done_sh_l_enable", sh_l_enable, 0);
        if (bus_if.rsp_ready) m_active = 1'b0;
      end
    end
  end

  task automatic waitAccept(output int acc);
    bit ok = 1'b0;
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_if.req_ready && bus_if.req_valid) begin
        acc = cyc;
        ok  = 1'b1;
        break;
      end
    end
    checkOutput("accept_seen", ok, 1);
  endtask

  task automatic waitRsp(input string tag, input int acc, input logic [31:0] exp_res, input int exp_lat);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_rsp_seen"}, ok, 1);
    checkOutput({tag, "_latency"}, cyc - acc, exp_lat);
    checkOutput({tag, "_result"}, bus_if.rsp_result, exp_res);
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
  endtask

  // Inputs are scrambled after accept to show they are not resampled
  task automatic applyStimulus(input string tag, input logic [31:0] op, input logic [5:0] amt,
                               input logic dir, input logic [31:0] exp_res, input int exp_lat);
    int acc;
    @(posedge clk); #1;
    bus_if.req_operand = op;
    bus_if.req_amt     = amt;
    bus_if.req_dir     = dir;
    bus_if.req_valid   = 1'b1;
    waitAccept(acc);
    @(posedge clk); #1;
    bus_if.req_valid   = 1'b0;
    bus_if.req_operand = ~op;
    bus_if.req_amt     = 6'($urandom_range(0, 63));
    bus_if.req_dir     = ~dir;
    waitRsp(tag, acc, exp_res, exp_lat);
    handshake();
  endtask

  typedef struct {
    string       tag;
    logic [31:0] op;
    logic [5:0]  amt;
    logic        dir;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[7];
  int   sat_lat;
  int   acc_a;
  int   acc_b;
  int   hs_cyc;
  bit   saw_valid;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    m_active = 1'b0;
    reset_n  = 1'b0;
    bus_if.req_valid   = 1'b0;
    bus_if.req_operand = '0;
    bus_if.req_amt     = '0;
    bus_if.req_dir     = 1'b0;
    bus_if.rsp_ready   = 1'b0;
`ifdef ALU_SHIFT_CTRL_SAT_BYPASS_EN
    sat_lat = 1;
`else
    sat_lat = 35;
`endif
    vecs[0] = '{"shl4",   32'h0000_0001, 6'd4,  1'b0, 32'h0000_0010, 7};
    vecs[1] = '{"shr31",  32'h8000_0000, 6'd31, 1'b1, 32'h0000_0001, 34};
    vecs[2] = '{"amt0",   32'hDEAD_BEEF, 6'd0,  1'b0, 32'hDEAD_BEEF, 3};
    vecs[3] = '{"sat40",  32'hFFFF_FFFF, 6'd40, 1'b0, 32'h0000_0000, sat_lat};
    vecs[4] = '{"shr8",   32'h1234_5678, 6'd8,  1'b1, 32'h0012_3456, 11};
    vecs[5] = '{"sat32",  32'hA5A5_A5A5, 6'd32, 1'b1, 32'h0000_0000, sat_lat};
    vecs[6] = '{"shl1",   32'h8000_0001, 6'd1,  1'b0, 32'h0000_0002, 4};

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i])
      applyStimulus(vecs[i].tag, vecs[i].op, vecs[i].amt, vecs[i].dir, vecs[i].exp, vecs[i].lat);

    // Response stall with a second request waiting behind it
    @(posedge clk); #1;
    bus_if.req_operand = 32'h0000_00F0;
    bus_if.req_amt     = 6'd4;
    bus_if.req_dir     = 1'b1;
    bus_if.req_valid   = 1'b1;
    waitAccept(acc_a);
    @(posedge clk); #1;
    bus_if.req_operand = 32'h0000_0003;
    bus_if.req_amt     = 6'd2;
    bus_if.req_dir     = 1'b0;
    waitRsp("stallA", acc_a, 32'h0000_000F, 7);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_result_held", bus_if.rsp_result, 32'h0000_000F);
    checkOutput("stall_req_ready", bus_if.req_ready, 0);
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    hs_cyc = cyc;
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b0;
    waitAccept(acc_b);
    checkOutput("stall_next_accept", acc_b - hs_cyc, 1);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    waitRsp("stallB", acc_b, 32'h0000_000C, 5);
    handshake();

    // Reset in the middle of SHIFT
    @(posedge clk); #1;
    bus_if.req_operand = 32'h0F0F_0F0F;
    bus_if.req_amt     = 6'd20;
    bus_if.req_dir     = 1'b1;
    bus_if.req_valid   = 1'b1;
    waitAccept(acc_a);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", bus_if.rsp_valid, 0);
    checkOutput("abort_rsp_result", bus_if.rsp_result, 0);
    checkOutput("abort_req_ready", bus_if.req_ready, 1);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_sh_l_enable", sh_l_enable, 0);
    checkOutput("abort_sh_operand", sh_operand, 0);
    checkOutput("abort_sh_dir", sh_shift_l_r, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    saw_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus_if.rsp_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_rsp", saw_valid, 0);
    checkOutput("abort_ready_after", bus_if.req_ready, 1);

    applyStimulus("post_abort", 32'h0000_0101, 6'd3, 1'b0, 32'h0000_0808, 6);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
